// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg
//   Shared definitions for the RV32I instruction encoder: base opcodes,
//   the canonical NOP word and the instruction-format classification.
package riscv_enc_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e op_format(input logic [6:0] op);
        case (op)
            OP_R:                   return FMT_R;
            OP_I, OP_JALR, OP_LOAD: return FMT_I;
            OP_STORE:               return FMT_S;
            OP_BRANCH:              return FMT_B;
            OP_LUI:                 return FMT_U;
            OP_JAL:                 return FMT_J;
            default:                return FMT_BAD;
        endcase
    endfunction

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer
//   Combinational packing of decoded RV32I fields and a flat, unscaled
//   immediate into a 32-bit instruction word, with a range/alignment error.
// Ports:
//   op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i  decoded fields
//   imm_i     two's complement byte immediate
//   instr_o   packed instruction (NOP for unsupported opcodes)
//   err_o     unsupported opcode, immediate out of range, or odd B/J offset
module instr_field_packer
    import riscv_enc_pkg::*;
(
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic signed [31:0] imm;
    fmt_e               fmt;

    assign imm = imm_i;
    assign fmt = op_format(op_i);

    // Out-of-range immediates still pack their low bits; only err_o flags them.
    always_comb begin
        instr_o = NOP_INSTR;
        err_o   = 1'b1;
        case (fmt)
            FMT_R: begin
                instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
                err_o   = 1'b0;
            end
            FMT_I: begin
                instr_o = {imm[11:0], rs1_i, funct3_i, rd_i, op_i};
                // Load offsets are restricted to the non-negative half.
                if (op_i == OP_LOAD) err_o = !in_range(imm, 0, 2047);
                else                 err_o = !in_range(imm, -2048, 2047);
            end
            FMT_S: begin
                instr_o = {imm[11:5], rs2_i, rs1_i, funct3_i, imm[4:0], op_i};
                err_o   = !in_range(imm, 0, 2047);
            end
            FMT_B: begin
                instr_o = {imm[12], imm[10:5], rs2_i, rs1_i, funct3_i,
                           imm[4:1], imm[11], op_i};
                err_o   = !in_range(imm, -4096, 4094) || imm[0];
            end
            FMT_U: begin
                instr_o = {imm[19:0], rd_i, op_i};
                err_o   = !in_range(imm, -524288, 524287);
            end
            FMT_J: begin
                instr_o = {imm[20], imm[10:1], imm[11], imm[19:12], rd_i, op_i};
                err_o   = !in_range(imm, 0, 32'h001F_FFFE) || imm[0];
            end
            default: begin
                instr_o = NOP_INSTR;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Two-stage valid/ready pipeline that encodes RV32I words and stamps each
//   with an incrementing instruction-memory word address.
// Ports:
//   clk, reset (async, active-low), start_i (sync flush/clear)
//   req_*        request handshake and decoded fields / immediate
//   instr_*      output handshake, word, word address, error flag
//   err_count_o  saturating count of errored words emitted
//   wrap_o       sticky flag: the address counter wrapped
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [6:0]            op_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [31:0]           imm_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_err_o,
    output logic [7:0]            err_count_o,
    output logic                  wrap_o
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0]           pack_instr;
    logic                  pack_err;

    logic                  s1_valid_q, s1_valid_d;
    logic [31:0]           s1_instr_q, s1_instr_d;
    logic                  s1_err_q,   s1_err_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [31:0]           s2_instr_q, s2_instr_d;
    logic                  s2_err_q,   s2_err_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q,  s2_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [7:0]            err_count_q, err_count_d;
    logic                  wrap_q,     wrap_d;

    logic                  s1_adv;
    logic                  req_acc;
    logic                  out_acc;

    instr_field_packer u_packer (
        .op_i     (op_i),
        .rd_i     (rd_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .imm_i    (imm_i),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    assign s1_adv  = s1_valid_q && (!s2_valid_q || instr_ready_i);
    // Gated by reset so the request side reads not-ready while held in reset.
    assign req_ready_o = reset && !start_i && (!s1_valid_q || s1_adv);
    assign req_acc = req_valid_i && req_ready_o;
    assign out_acc = s2_valid_q && instr_ready_i;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        s1_err_d    = s1_err_q;
        s1_addr_d   = s1_addr_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_err_d    = s2_err_q;
        s2_addr_d   = s2_addr_q;
        addr_d      = addr_q;
        err_count_d = err_count_q;
        wrap_d      = wrap_q;
        if (start_i) begin
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
            addr_d      = '0;
            err_count_d = 8'd0;
            wrap_d      = 1'b0;
        end else begin
            // Stage 1 -> stage 2
            if (s1_adv) begin
                s2_valid_d = 1'b1;
                s2_instr_d = s1_instr_q;
                s2_err_d   = s1_err_q;
                s2_addr_d  = s1_addr_q;
            end else if (out_acc) begin
                s2_valid_d = 1'b0;
            end
            // Request -> stage 1
            if (req_acc) begin
                s1_valid_d = 1'b1;
                s1_instr_d = pack_instr;
                s1_err_d   = pack_err;
                s1_addr_d  = addr_q;
                addr_d     = addr_q + ADDR_WIDTH'(1);
                if (&addr_q) wrap_d = 1'b1;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
            if (out_acc && s2_err_q) err_count_d = sat_inc8(err_count_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= 32'd0;
            s2_err_q    <= 1'b0;
            s2_addr_q   <= '0;
            addr_q      <= '0;
            err_count_q <= 8'd0;
            wrap_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            s2_addr_q   <= s2_addr_d;
            addr_q      <= addr_d;
            err_count_q <= err_count_d;
            wrap_q      <= wrap_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_instr_q <= s1_instr_d;
        s1_err_q   <= s1_err_d;
        s1_addr_q  <= s1_addr_d;
    end

    assign instr_valid_o = s2_valid_q;
    assign instr_o       = s2_instr_q;
    assign instr_err_o   = s2_err_q;
    assign instr_addr_o  = s2_addr_q;
    assign err_count_o   = err_count_q;
    assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [6:0]    op_i;
    logic [4:0]    rd_i, rs1_i, rs2_i;
    logic [2:0]    funct3_i;
    logic [6:0]    funct7_i;
    logic [31:0]   imm_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [AW-1:0] instr_addr_o;
    logic          instr_err_o;
    logic [7:0]    err_count_o;
    logic          wrap_o;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .op_i          (op_i),
        .rd_i          (rd_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .funct3_i      (funct3_i),
        .funct7_i      (funct7_i),
        .imm_i         (imm_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .instr_err_o   (instr_err_o),
        .err_count_o   (err_count_o),
        .wrap_o        (wrap_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          m_addr = 0;
    int          m_errcnt = 0;
    logic        m_wrap = 1'b0;
    int          cyc = 0;
    bit          exact_lat = 1'b0;
    logic [31:0] last_instr, last_addr;
    logic        last_err;

    function automatic logic [31:0] fld(input logic [31:0] u, input int hi, input int lo);
        return (u >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
    endfunction

    // Builds the word from the instruction-set field layout using shifts/masks.
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input int imm, output logic [31:0] w, output logic e);
        logic [31:0] u;
        logic [31:0] regs;
        bit odd;
        u = imm;
        odd = (imm % 2) != 0;
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h33: begin
                w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
                e = 1'b0;
            end
            7'h13, 7'h67, 7'h03: begin
                w = (fld(u, 11, 0) << 20) | regs | (32'(rd) << 7);
                if (op == 7'h03) e = (imm < 0) || (imm > 2047);
                else             e = (imm < -2048) || (imm > 2047);
            end
            7'h23: begin
                w = (fld(u, 11, 5) << 25) | (32'(rs2) << 20) | regs | (fld(u, 4, 0) << 7);
                e = (imm < 0) || (imm > 2047);
            end
            7'h63: begin
                w = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (32'(rs2) << 20) | regs
                  | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7);
                e = (imm < -4096) || (imm > 4094) || odd;
            end
            7'h37: begin
                w = (fld(u, 19, 0) << 12) | (32'(rd) << 7) | 32'(op);
                e = (imm < -524288) || (imm > 524287);
            end
            7'h6F: begin
                w = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20)
                  | (fld(u, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
                e = (imm < 0) || (imm > 32'h1FFFFE) || odd;
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
    endfunction

    // One clock: observe at negedge, update scoreboard, return just after posedge.
    task automatic step(output bit acc, output bit popped);
        exp_t e;
        logic [31:0] w;
        logic er;
        @(negedge clk);
        cyc++;
        chk("err_count", 32'(err_count_o), 32'(m_errcnt));
        chk("wrap", 32'(wrap_o), 32'(m_wrap));
        acc = 1'b0;
        popped = 1'b0;
        if (start_i) begin
            chk("ready_during_start", 32'(req_ready_o), 32'd0);
            q.delete();
            m_addr = 0;
            m_errcnt = 0;
            m_wrap = 1'b0;
        end else begin
            if (instr_valid_o && instr_ready_i) begin
                if (q.size() == 0) begin
                    chk("spurious_word", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("instr", instr_o, e.instr);
                    chk("instr_err", 32'(instr_err_o), 32'(e.err));
                    chk("instr_addr", 32'(instr_addr_o), e.addr);
                    if (exact_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                    popped = 1'b1;
                    last_instr = instr_o;
                    last_err = instr_err_o;
                    last_addr = 32'(instr_addr_o);
                    if (e.err && m_errcnt < 255) m_errcnt++;
                end
            end
            if (req_valid_i && req_ready_o) begin
                ref_encode(op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, int'(imm_i), w, er);
                e.instr = w;
                e.err = er;
                e.addr = 32'(m_addr);
                e.cyc = cyc;
                q.push_back(e);
                if (m_addr == (1 << AW) - 1) begin
                    m_addr = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_addr++;
                end
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_wait();
        bit a, p, ok;
        ok = 1'b0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            step(a, p);
            if (a) ok = 1'b1;
        end
        req_valid_i = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit a, p;
        for (int i = 0; i < 200 && q.size() != 0; i++) step(a, p);
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic do_start();
        bit a, p;
        start_i = 1'b1;
        step(a, p);
        start_i = 1'b0;
        chk("valid_after_start", 32'(instr_valid_o), 32'd0);
    endtask

    task automatic rand_req();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F, 7'h00};
        int lo, hi;
        bit bad;
        op_i = ops[$urandom_range(9)];
        rd_i = 5'($urandom);
        rs1_i = 5'($urandom);
        rs2_i = 5'($urandom);
        funct3_i = 3'($urandom);
        funct7_i = 7'($urandom);
        bad = ($urandom_range(7) == 0);
        case (op_i)
            7'h13, 7'h67: begin lo = -2048; hi = 2047; end
            7'h03, 7'h23: begin lo = 0; hi = 2047; end
            7'h63:        begin lo = -4096; hi = 4094; end
            7'h37:        begin lo = -524288; hi = 524287; end
            7'h6F:        begin lo = 0; hi = 32'h1FFFFE; end
            default:      begin lo = -100; hi = 100; end
        endcase
        if (bad) imm_i = $urandom;
        else     imm_i = 32'(lo + int'($urandom_range(32'(hi - lo))));
        if (!bad && (op_i == 7'h63 || op_i == 7'h6F)) imm_i[0] = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t tbl[18];

    initial begin
        bit a, p;
        int n, npop, guard;

        tbl[0]  = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, -1,        32'hFFF10093, 1'b0};
        tbl[1]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -8,        32'hFE208CE3, 1'b0};
        tbl[2]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 'h800,     32'h001000EF, 1'b0};
        tbl[3]  = '{7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 2048,      32'h80312023, 1'b1};
        tbl[4]  = '{7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 0,         32'h00000013, 1'b1};
        tbl[5]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 3,         32'h00000163, 1'b1};
        tbl[6]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 'h12345,   32'h123452B7, 1'b0};
        tbl[7]  = '{7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 0,         32'h403100B3, 1'b0};
        tbl[8]  = '{7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, 4,         32'h00412083, 1'b0};
        tbl[9]  = '{7'h03, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, -4,        32'hFFC12083, 1'b1};
        tbl[10] = '{7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 0,         32'h00008067, 1'b0};
        tbl[11] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 3,         32'h0020006F, 1'b1};
        tbl[12] = '{7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 'h80000,   32'h80000037, 1'b1};
        tbl[13] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 2047,      32'h7FF00093, 1'b0};
        tbl[14] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 2048,      32'h80000093, 1'b1};
        tbl[15] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 4094,      32'h7E000FE3, 1'b0};
        tbl[16] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 'h1FFFFE,  32'hFFFFF06F, 1'b0};
        tbl[17] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, -4096,     32'h80000063, 1'b0};

        start_i = 1'b0; req_valid_i = 1'b0; instr_ready_i = 1'b0;
        op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0; imm_i = '0;

        // Power-on reset
        #1 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_errcnt", 32'(err_count_o), 32'd0);
        #2 reset = 1'b1;
        #1 chk("ready_after_release", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;

        // Table vectors, one at a time, output always ready
        exact_lat = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            op_i = tbl[i].op; rd_i = tbl[i].rd; rs1_i = tbl[i].rs1; rs2_i = tbl[i].rs2;
            funct3_i = tbl[i].f3; funct7_i = tbl[i].f7; imm_i = tbl[i].imm;
            send_wait();
            drain();
            chk($sformatf("tbl%0d_instr", i), last_instr, tbl[i].instr);
            chk($sformatf("tbl%0d_err", i), 32'(last_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_addr", i), last_addr, 32'(i));
        end
        chk("tbl_err_count", 32'(err_count_o), 32'd7);
        exact_lat = 1'b0;

        // Backpressure: 4 back-to-back requests, consumer stalled 5 cycles
        do_start();
        instr_ready_i = 1'b0;
        n = 0;
        guard = 0;
        rand_req();
        req_valid_i = 1'b1;
        while (n < 2 && guard < 20) begin
            step(a, p);
            guard++;
            if (a) begin n++; rand_req(); end
        end
        chk("bp_ready_low", 32'(req_ready_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(a, p);
            chk("bp_hold_ready_low", 32'(req_ready_o), 32'd0);
        end
        instr_ready_i = 1'b1;
        npop = 0;
        guard = 0;
        while ((n < 4 || q.size() != 0) && guard < 40) begin
            step(a, p);
            guard++;
            if (a) begin
                n++;
                if (n < 4) rand_req();
                else req_valid_i = 1'b0;
            end
            if (p) begin
                chk("bp_order_addr", last_addr, 32'(npop));
                npop++;
            end
        end
        req_valid_i = 1'b0;
        chk("bp_word_count", 32'(npop), 32'd4);

        // Randomized traffic with random backpressure
        do_start();
        rand_req();
        req_valid_i = 1'b0;
        for (int i = 0; i < 600; i++) begin
            instr_ready_i = ($urandom_range(9) < 7);
            step(a, p);
            if (a || !req_valid_i) begin
                rand_req();
                req_valid_i = ($urandom_range(9) < 7);
            end
        end
        req_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        drain();

        // Error-count saturation and address wrap
        do_start();
        instr_ready_i = 1'b1;
        op_i = 7'h7F;
        req_valid_i = 1'b1;
        for (int i = 0; i < 262; i++) step(a, p);
        req_valid_i = 1'b0;
        drain();
        chk("err_count_saturated", 32'(err_count_o), 32'd255);
        chk("wrap_set", 32'(wrap_o), 32'd1);

        // start_i mid-stream with words in flight and a same-cycle request
        rand_req();
        req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(a, p);
            if (a) rand_req();
        end
        start_i = 1'b1;
        step(a, p);
        start_i = 1'b0;
        req_valid_i = 1'b0;
        chk("start_valid_low", 32'(instr_valid_o), 32'd0);
        chk("start_wrap_clear", 32'(wrap_o), 32'd0);
        chk("start_errcnt_clear", 32'(err_count_o), 32'd0);
        rand_req();
        send_wait();
        drain();
        chk("start_first_addr", last_addr, 32'd0);

        // Reset with two words in flight
        op_i = 7'h7F;
        send_wait();
        drain();
        instr_ready_i = 1'b0;
        rand_req();
        req_valid_i = 1'b1;
        n = 0;
        guard = 0;
        while (n < 2 && guard < 20) begin
            step(a, p);
            guard++;
            if (a) begin n++; rand_req(); end
        end
        req_valid_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("async_rst_instr", instr_o, 32'd0);
        chk("async_rst_addr", 32'(instr_addr_o), 32'd0);
        chk("async_rst_errcnt", 32'(err_count_o), 32'd0);
        chk("async_rst_wrap", 32'(wrap_o), 32'd0);
        chk("async_rst_ready", 32'(req_ready_o), 32'd0);
        q.delete();
        m_addr = 0;
        m_errcnt = 0;
        m_wrap = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst2_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        instr_ready_i = 1'b1;
        rand_req();
        send_wait();
        drain();
        chk("rst2_first_addr", last_addr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
